// File: rtl/fetch_controller_pkg.sv
// Shared types and constants for the instruction fetch controller.
// Optional feature macro: FETCH_PERF_EN (see fetch_controller.sv).
package fetch_controller_pkg;

    typedef enum logic [1:0] {
        BOOT  = 2'd0,
        FETCH = 2'd1,
        FULL  = 2'd2
    } fetch_state_e;

    localparam logic [31:0] PC_STEP          = 32'd4;
    localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
    } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// DEPTH-entry fetch buffer (DEPTH = 2 or 4) with push/pop/flush and occupancy count.
// The head output holds its last shown value while the buffer is empty.
module fetch_fifo
    import fetch_controller_pkg::*;
#(
    parameter int unsigned DEPTH = 2
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           push_i,
    input  logic                           pop_i,
    input  logic                           flush_i,
    input  fetch_entry_t                   wdata_i,
    output fetch_entry_t                   rdata_o,
    output logic [$clog2(DEPTH+1)-1:0]     count_o
);

    localparam int unsigned CW = $clog2(DEPTH + 1);
    localparam int unsigned PW = $clog2(DEPTH);

    fetch_entry_t          mem_q [DEPTH];
    fetch_entry_t          last_q;
    logic [PW-1:0]         head_q;
    logic [PW-1:0]         tail_q;
    logic [CW-1:0]         count_q;

    assign count_o = count_q;
    assign rdata_o = (count_q != '0) ? mem_q[head_q] : last_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            last_q  <= '0;
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            last_q <= rdata_o;
            if (flush_i) begin
                head_q  <= '0;
                tail_q  <= '0;
                count_q <= '0;
            end else begin
                if (push_i) begin
                    mem_q[tail_q] <= wdata_i;
                    tail_q        <= tail_q + PW'(1);
                end
                if (pop_i) begin
                    head_q <= head_q + PW'(1);
                end
                count_q <= count_q + CW'(push_i) - CW'(pop_i);
            end
        end
    end

endmodule

// File: rtl/fetch_controller.sv
// Instruction fetch controller: PC generation, BOOT/FETCH/FULL FSM, fetch buffer.
// Define FETCH_PERF_EN to add saturating perf_fetched / perf_stall counters.
module fetch_controller
    import fetch_controller_pkg::*;
#(
    parameter logic [31:0] RESET_PC  = DEFAULT_RESET_PC,
    parameter int unsigned BUF_DEPTH = 2
) (
    input  logic        clk,
    input  logic        rst,
`ifdef FETCH_PERF_EN
    output logic [31:0] perf_fetched,
    output logic [31:0] perf_stall,
`endif
    output logic [31:0] imem_pc,
    input  logic [31:0] imem_instr,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        if_valid,
    output logic [31:0] if_pc,
    output logic [31:0] if_instr,
    input  logic        if_ready
);

    localparam int unsigned CW = $clog2(BUF_DEPTH + 1);

    fetch_state_e   state_q, state_d;
    logic [31:0]    fetch_pc_q, fetch_pc_d;
    logic [CW-1:0]  count;
    logic [CW-1:0]  count_d;
    logic           push;
    logic           pop;
    fetch_entry_t   wentry;
    fetch_entry_t   head;
    logic [1:0]     unused_redirect_lsbs;

    assign unused_redirect_lsbs = redirect_pc[1:0];

    assign imem_pc  = fetch_pc_q;
    assign if_valid = (count != '0);
    assign if_pc    = head.pc;
    assign if_instr = head.instr;
    assign wentry   = '{pc: fetch_pc_q, instr: imem_instr};

    always_comb begin
        pop        = if_valid && if_ready && !redirect_valid;
        push       = (state_q != BOOT) && ((count < CW'(BUF_DEPTH)) || pop) && !redirect_valid;
        count_d    = redirect_valid ? '0 : (count + CW'(push) - CW'(pop));
        fetch_pc_d = fetch_pc_q;
        state_d    = state_q;
        if (redirect_valid) begin
            fetch_pc_d = {redirect_pc[31:2], 2'b00};
        end else if (push) begin
            fetch_pc_d = fetch_pc_q + PC_STEP;
        end
        case (state_q)
            BOOT:    state_d = FETCH;
            FETCH:   if (!redirect_valid && count_d == CW'(BUF_DEPTH)) state_d = FULL;
            FULL:    if (redirect_valid || pop) state_d = FETCH;
            default: state_d = BOOT;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= BOOT;
            fetch_pc_q <= RESET_PC;
        end else begin
            state_q    <= state_d;
            fetch_pc_q <= fetch_pc_d;
        end
    end

    fetch_fifo #(
        .DEPTH (BUF_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .push_i  (push),
        .pop_i   (pop),
        .flush_i (redirect_valid),
        .wdata_i (wentry),
        .rdata_o (head),
        .count_o (count)
    );

`ifdef FETCH_PERF_EN
    logic [31:0] perf_fetched_q, perf_fetched_d;
    logic [31:0] perf_stall_q, perf_stall_d;

    assign perf_fetched = perf_fetched_q;
    assign perf_stall   = perf_stall_q;

    always_comb begin
        perf_fetched_d = perf_fetched_q;
        perf_stall_d   = perf_stall_q;
        if (push && perf_fetched_q != '1) perf_fetched_d = perf_fetched_q + 32'd1;
        if (if_valid && !if_ready && perf_stall_q != '1) perf_stall_d = perf_stall_q + 32'd1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            perf_fetched_q <= '0;
            perf_stall_q   <= '0;
        end else begin
            perf_fetched_q <= perf_fetched_d;
            perf_stall_q   <= perf_stall_d;
        end
    end
`endif

endmodule

// File: tb/tb_fetch_controller.sv
// Self-checking bench for fetch_controller against a queue-based fetch model.
// Builds with or without FETCH_PERF_EN.
module tb_fetch_controller;
    import fetch_controller_pkg::*;

    localparam int          D   = 2;
    localparam logic [31:0] RPC = 32'h0000_0000;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] imem_pc;
    logic [31:0] imem_instr;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        if_valid;
    logic [31:0] if_pc;
    logic [31:0] if_instr;
    logic        if_ready;
`ifdef FETCH_PERF_EN
    logic [31:0] perf_fetched;
    logic [31:0] perf_stall;
`endif

    logic [31:0] imem [256];
    assign imem_instr = imem[imem_pc[9:2]];

    always #5 clk = ~clk;

    fetch_controller #(
        .RESET_PC  (RPC),
        .BUF_DEPTH (D)
    ) dut (
        .clk            (clk),
        .rst            (rst),
`ifdef FETCH_PERF_EN
        .perf_fetched   (perf_fetched),
        .perf_stall     (perf_stall),
`endif
        .imem_pc        (imem_pc),
        .imem_instr     (imem_instr),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .if_valid       (if_valid),
        .if_pc          (if_pc),
        .if_instr       (if_instr),
        .if_ready       (if_ready)
    );

    int checks   = 0;
    int failures = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h @%0t", tag, got, exp, $time);
        end
    endtask

    // Reference model: ordered queue of buffered fetch addresses.
    logic [31:0] mq [$];
    logic [31:0] mpc;
    bit          mboot;
    logic [31:0] last_pc;
    logic [31:0] last_instr;

    function automatic logic [31:0] instr_of(input logic [31:0] pc);
        return imem[pc[9:2]];
    endfunction

    task automatic model_reset();
        mq.delete();
        mpc        = RPC;
        mboot      = 1'b1;
        last_pc    = '0;
        last_instr = '0;
    endtask

    task automatic cycle(input bit rdy, input bit rd, input logic [31:0] rpc);
        bit          exp_v, pop, push;
        int          n;
        logic [31:0] exp_pc, exp_in;
        if_ready       = rdy;
        redirect_valid = rd;
        redirect_pc    = rpc;
        @(negedge clk);
        exp_v  = (mq.size() != 0);
        exp_pc = exp_v ? mq[0] : last_pc;
        exp_in = exp_v ? instr_of(mq[0]) : last_instr;
        check_eq("if_valid", {31'b0, if_valid}, {31'b0, exp_v});
        check_eq("imem_pc", imem_pc, mpc);
        check_eq("if_pc", if_pc, exp_pc);
        check_eq("if_instr", if_instr, exp_in);
        if (rd) begin
            mq.delete();
            mpc = {rpc[31:2], 2'b00};
        end else begin
            n    = mq.size();
            pop  = exp_v && rdy;
            push = !mboot && ((n < D) || pop);
            if (pop) void'(mq.pop_front());
            if (push) begin
                mq.push_back(mpc);
                mpc = mpc + 32'd4;
            end
        end
        mboot      = 1'b0;
        last_pc    = exp_pc;
        last_instr = exp_in;
        @(posedge clk);
        #1;
    endtask

    initial begin
        for (int i = 0; i < 256; i++) imem[i] = $urandom;
        rst            = 1'b1;
        if_ready       = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = '0;

        // Values held while reset is asserted
        repeat (2) @(posedge clk);
        @(negedge clk);
        check_eq("rst_valid", {31'b0, if_valid}, 32'd0);
        check_eq("rst_imem_pc", imem_pc, RPC);
        check_eq("rst_if_pc", if_pc, 32'd0);
        check_eq("rst_if_instr", if_instr, 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        model_reset();

        // Streaming from reset with if_ready high
        repeat (6) cycle(1'b1, 1'b0, '0);

        // Stall from reset: buffer fills, fetch holds at 8
        rst = 1'b1;
        #1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        model_reset();
        repeat (5) cycle(1'b0, 1'b0, '0);
        @(negedge clk);
        check_eq("full_imem_pc", imem_pc, 32'h8);
        check_eq("full_state", {30'b0, dut.state_q}, {30'b0, FULL});
        @(posedge clk);
        #1;
        repeat (5) cycle(1'b1, 1'b0, '0);

        // Redirect while full, unaligned target
        repeat (4) cycle(1'b0, 1'b0, '0);
        cycle(1'b0, 1'b1, 32'h0000_0013);
        repeat (4) cycle(1'b1, 1'b0, '0);

        // Redirect with stall while a push was possible
        cycle(1'b0, 1'b0, '0);
        cycle(1'b0, 1'b1, 32'h0000_0040);
        @(negedge clk);
        check_eq("redir_count", 32'(dut.count), 32'd0);
        @(posedge clk);
        #1;
        repeat (3) cycle(1'b1, 1'b0, '0);

        // Redirect to top of address space, wrap to zero
        cycle(1'b1, 1'b1, 32'hFFFF_FFFC);
        repeat (4) cycle(1'b1, 1'b0, '0);

        // Randomized traffic
        for (int i = 0; i < 400; i++) begin
            cycle(($urandom_range(0, 3) != 0), ($urandom_range(0, 15) == 0), $urandom);
        end

        // Asynchronous reset with two entries buffered
        cycle(1'b0, 1'b1, 32'h0000_0100);
        repeat (3) cycle(1'b0, 1'b0, '0);
        check_eq("pre_rst_valid", {31'b0, if_valid}, 32'd1);
        #2;
        rst = 1'b1;
        #1;
        check_eq("async_valid", {31'b0, if_valid}, 32'd0);
        check_eq("async_imem_pc", imem_pc, RPC);
`ifdef FETCH_PERF_EN
        check_eq("perf_fetched_rst", perf_fetched, 32'd0);
        check_eq("perf_stall_rst", perf_stall, 32'd0);
`else
        check_eq("async_if_pc", if_pc, 32'd0);
`endif
        @(posedge clk);
        #1;
        rst = 1'b0;
        model_reset();
        repeat (6) cycle(1'b1, 1'b0, '0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/fetch_controller.md
FETCH_CONTROLLER -- requirements
Module: fetch_controller

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_0000: first fetch address after reset.
REQ-002 Parameter BUF_DEPTH, default 2: fetch-buffer entries; legal values 2 or 4.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst  input  1  asynchronous, active-high reset.
REQ-005 imem_pc  output  32  byte address driven to the combinational instruction memory; word index is pc[9:2].
REQ-006 imem_instr  input  32  instruction returned by the memory in the same cycle as imem_pc.
REQ-007 redirect_valid  input  1  branch/jump resolved taken; flush and refetch.
REQ-008 redirect_pc  input  32  new fetch address; bits [1:0] forced to 0 internally.
REQ-009 if_valid  output  1  buffer head holds a valid instruction.
REQ-010 if_pc  output  32  byte address of head instruction.
REQ-011 if_instr  output  32  head instruction word.
REQ-012 if_ready  input  1  IF/ID stage accepts head this cycle; low means stall.

Function
REQ-013 FSM states: BOOT, FETCH, FULL; BOOT lasts exactly one cycle after rst deasserts, with no fetch issued.
REQ-014 BOOT->FETCH unconditionally; FETCH->FULL when count reaches BUF_DEPTH; FULL->FETCH on a pop or a redirect.
REQ-015 Push condition: state != BOOT and (count < BUF_DEPTH or pop this cycle) and redirect_valid == 0.
REQ-016 On push, {imem_pc, imem_instr} is written at the tail and fetch_pc advances by 4, wrapping 32'hFFFF_FFFC -> 32'h0000_0000.
REQ-017 Pop occurs when if_valid and if_ready are both 1; head advances the next cycle.
REQ-018 Latency: an instruction fetched in cycle N appears on if_valid/if_instr no earlier than cycle N+1.
REQ-019 Simultaneous push and pop with count == BUF_DEPTH is allowed; count is unchanged.
REQ-020 redirect_valid has priority over push, pop and stall: buffer is emptied, fetch_pc <= {redirect_pc[31:2], 2'b00}, and no push occurs in that cycle.
REQ-021 if_valid is 0 in the cycle after a redirect; the first redirected instruction appears one cycle later.
REQ-022 When if_valid = 0, if_pc and if_instr hold their previous values; consumers ignore them.
REQ-023 Instructions leave the buffer strictly in fetch order; there is no drop or duplication without a redirect.

Reset
REQ-024 While rst = 1: state = BOOT, count = 0, head/tail = 0, fetch_pc = RESET_PC, imem_pc = RESET_PC, if_valid = 0, if_pc = 0, if_instr = 0.
REQ-025 rst asserted mid-operation discards all buffered entries immediately, without waiting for a clock edge.

Configuration
REQ-026 Macro FETCH_PERF_EN, when defined: adds outputs perf_fetched[31:0] (push count) and perf_stall[31:0] (cycles with if_valid=1 and if_ready=0); both counters saturate at 32'hFFFF_FFFF and reset to 0.
REQ-027 Without FETCH_PERF_EN: neither port nor counter exists, and all other behaviour is identical.

Structure
REQ-028 A shared package holds the FSM state encoding (BOOT=2'd0, FETCH=2'd1, FULL=2'd2), the constants PC_STEP=4 and the beq/default RESET_PC value, and the fetch-entry struct {pc, instr}.
REQ-029 A single sub-module, fetch_fifo, implements the BUF_DEPTH-entry FIFO with push/pop/flush/count; the FSM and PC logic stay in fetch_controller.

Verification
REQ-030 Reset release with if_ready=1: first cycle imem_pc=0 and if_valid=0; then if_pc sequence 0,4,8,12 on consecutive cycles.
REQ-031 if_ready=0 for 5 cycles from reset: buffer fills with pc 0 and 4; state=FULL; imem_pc holds 8; on release, pcs 0,4,8 appear in order with none lost.
REQ-032 Redirect to 32'h0000_0013 while FULL: buffer flushes; next valid if_pc=32'h0000_0010; stale pcs never appear.
REQ-033 Redirect and if_ready=0 in the same cycle as a push opportunity: redirect wins, count=0, and nothing is pushed.
REQ-034 Redirect to 32'hFFFF_FFFC with if_ready=1: pcs FFFF_FFFC then 0000_0000 (wrap).
REQ-035 rst pulse asserted asynchronously mid-stream with 2 entries buffered: if_valid drops before the next edge; restart from RESET_PC; with FETCH_PERF_EN, counters read 0.
